key_irq_ctrl: RTL and testbench

KEY_IRQ_CTRL -- requirements
Module: key_irq_ctrl

---
 rtl/key_irq_ctrl.sv | 165 ++++++++++++++++
 tb/tb_key_irq_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_irq_ctrl.sv
// Six-key debounce/auto-repeat front end feeding a single-vector interrupt requester.
// Events latch into pending flags; an IDLE/REQ/GUARD handshake serves them lowest index first.
module key_irq_ctrl #(
    parameter int unsigned DEB_TICKS = 4,
    parameter int unsigned REP_DELAY = 32,
    parameter int unsigned REP_RATE  = 8,
    parameter int unsigned VEC_BASE  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [3:0] btn,
    input  logic       Abtn,
    input  logic       Bbtn,
    input  logic       di,
    input  logic       irq_ack,
    output logic       irq_req,
    output logic [7:0] irq_vec,
    output logic [5:0] keys,
    output logic [5:0] pending,
    output logic       ovr
);
    localparam int unsigned NumKeys = 6;
    localparam int unsigned DebW    = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
    localparam int unsigned RepW    = 16;

    localparam logic [DebW-1:0] DebLast  = DebW'(DEB_TICKS - 1);
    localparam logic [RepW-1:0] RepDelay = RepW'(REP_DELAY);
    localparam logic [RepW-1:0] RepRate  = RepW'(REP_RATE);
    localparam logic [RepW-1:0] RepMax   = '1;

    typedef enum logic [1:0] {StIdle, StReq, StGuard} state_e;

    logic [NumKeys-1:0] sync1_q, sync1_d, sync2_q, sync2_d, pressed;
    logic [NumKeys-1:0] keys_q, keys_d, pending_q, pending_d, ev, clr;
    logic [DebW-1:0]    deb_q [NumKeys];
    logic [DebW-1:0]    deb_d [NumKeys];
    logic [RepW-1:0]    rep_q [NumKeys];
    logic [RepW-1:0]    rep_d [NumKeys];
    logic               ovr_q, ovr_d, req_q, req_d, guard_q, guard_d;
    logic [7:0]         vec_q, vec_d;
    logic [2:0]         k_q, k_d, low;
    state_e             state_q, state_d;

    // Raw buttons are active-low; index 0 is Bbtn, 1 is Abtn, 2..5 are btn[0..3].
    assign sync1_d = {btn, Abtn, Bbtn};
    assign sync2_d = sync1_q;
    assign pressed = ~sync2_q;

    always_comb begin
        keys_d = keys_q;
        ev     = '0;
        for (int i = 0; i < NumKeys; i++) begin
            deb_d[i] = deb_q[i];
            rep_d[i] = rep_q[i];
            if (tick) begin
                if (pressed[i] != keys_q[i]) begin
                    if (deb_q[i] == DebLast) begin
                        deb_d[i]  = '0;
                        keys_d[i] = ~keys_q[i];
                        rep_d[i]  = '0;
                        ev[i]     = ~keys_q[i];
                    end else begin
                        deb_d[i] = deb_q[i] + 1'b1;
                    end
                end else begin
                    deb_d[i] = '0;
                end
                // Repeat timing runs only while the key stays down; a saturated count stops repeats.
                if (keys_q[i] && keys_d[i] && (rep_q[i] != RepMax)) begin
                    rep_d[i] = rep_q[i] + 1'b1;
                    if ((rep_d[i] >= RepDelay) && (((rep_d[i] - RepDelay) % RepRate) == '0)) begin
                        ev[i] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        low = '0;
        for (int i = NumKeys - 1; i >= 0; i--) begin
            if (pending_q[i]) low = 3'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        vec_d   = vec_q;
        k_d     = k_q;
        guard_d = guard_q;
        clr     = '0;
        unique case (state_q)
            StIdle: begin
                if ((pending_q != '0) && !di) begin
                    k_d     = low;
                    vec_d   = 8'(VEC_BASE) + {4'b0000, low, 1'b0};
                    req_d   = 1'b1;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (irq_ack) begin
                    clr     = 6'(1) << k_q;
                    req_d   = 1'b0;
                    guard_d = 1'b0;
                    state_d = StGuard;
                end else if (di) begin
                    req_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            StGuard: begin
                if (guard_q) state_d = StIdle;
                else         guard_d = 1'b1;
            end
            default: state_d = StIdle;
        endcase
        // A new event in the same cycle as the ack keeps the flag and is not an overrun.
        pending_d = (pending_q & ~clr) | ev;
        ovr_d     = ovr_q | (|(ev & pending_q & ~clr));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            keys_q    <= '0;
            pending_q <= '0;
            ovr_q     <= 1'b0;
            state_q   <= StIdle;
            req_q     <= 1'b0;
            vec_q     <= '0;
            k_q       <= '0;
            guard_q   <= 1'b0;
            for (int i = 0; i < NumKeys; i++) begin
                deb_q[i] <= '0;
                rep_q[i] <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            keys_q    <= keys_d;
            pending_q <= pending_d;
            ovr_q     <= ovr_d;
            state_q   <= state_d;
            req_q     <= req_d;
            vec_q     <= vec_d;
            k_q       <= k_d;
            guard_q   <= guard_d;
            for (int i = 0; i < NumKeys; i++) begin
                deb_q[i] <= deb_d[i];
                rep_q[i] <= rep_d[i];
            end
        end
    end

    assign irq_req = req_q;
    assign irq_vec = vec_q;
    assign keys    = keys_q;
    assign pending = pending_q;
    assign ovr     = ovr_q;

endmodule

// File: tb/tb_key_irq_ctrl.sv
// Bench for key_irq_ctrl: directed scenarios plus random button traffic against a
// tick-level behavioural model of keys, pending flags, overrun and vector choice.
module tb_key_irq_ctrl;
    localparam int DEB  = 4;
    localparam int DLY  = 32;
    localparam int RATE = 8;

    logic       clk = 1'b0, rst = 1'b0, tick = 1'b0, di = 1'b0, irq_ack = 1'b0;
    logic       Abtn = 1'b1, Bbtn = 1'b1;
    logic [3:0] btn = 4'hf;
    logic       irq_req, ovr;
    logic [7:0] irq_vec;
    logic [5:0] keys, pending;

    key_irq_ctrl #(
        .DEB_TICKS(DEB),
        .REP_DELAY(DLY),
        .REP_RATE (RATE),
        .VEC_BASE (2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick),
        .btn    (btn),
        .Abtn   (Abtn),
        .Bbtn   (Bbtn),
        .di     (di),
        .irq_ack(irq_ack),
        .irq_req(irq_req),
        .irq_vec(irq_vec),
        .keys   (keys),
        .pending(pending),
        .ovr    (ovr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Model state: pressed/held are in ticks, pending is a plain set of key indices.
    logic [5:0] m_keys, m_pend, snap, raw_pins, raw_want;
    logic       m_ovr, req_prev, tick_was, ack_was, auto_ack, ack_now, di_want, any_req;
    int         m_deb [6];
    int         m_held[6];
    int         cur_k, ack_wait, phase, idle_cnt, rises;
    int         step_no, ack_step, rise_step, pend_step, gap_last;
    logic [7:0] vecs[$];

    function automatic int lowest(input logic [5:0] p);
        for (int i = 0; i < 6; i++) if (p[i]) return i;
        return 6;
    endfunction

    function automatic logic [7:0] vec_of(input int k);
        return 8'(2 + 2 * k);
    endfunction

    task automatic model_reset();
        m_keys = '0; m_pend = '0; snap = '0; m_ovr = 1'b0; req_prev = 1'b0;
        tick_was = 1'b0; ack_was = 1'b0; ack_now = 1'b0; ack_wait = 0; idle_cnt = 0;
        raw_pins = '0; raw_want = '0; cur_k = 0;
        for (int i = 0; i < 6; i++) begin
            m_deb[i]  = 0;
            m_held[i] = 0;
        end
    endtask

    task automatic model_tick(output logic [5:0] set);
        set = '0;
        for (int i = 0; i < 6; i++) begin
            logic flipped;
            flipped = 1'b0;
            if (raw_pins[i] != m_keys[i]) begin
                m_deb[i]++;
                if (m_deb[i] == DEB) begin
                    m_deb[i]  = 0;
                    m_keys[i] = ~m_keys[i];
                    m_held[i] = 0;
                    flipped   = 1'b1;
                    if (m_keys[i]) set[i] = 1'b1;
                end
            end else begin
                m_deb[i] = 0;
            end
            if (!flipped && m_keys[i]) begin
                m_held[i]++;
                if (m_held[i] >= DLY && ((m_held[i] - DLY) % RATE) == 0) set[i] = 1'b1;
            end
        end
    endtask

    // One clock: fold in the effects of the last posedge, compare, then drive the next inputs.
    task automatic step();
        logic [5:0] set, clr;
        int k;
        @(negedge clk);
        step_no++;
        set = '0;
        clr = '0;
        if (tick_was) model_tick(set);
        if (ack_was) clr = 6'(1) << cur_k;
        m_ovr = m_ovr | (|(set & m_pend & ~clr));
        if (m_pend == '0 && set != '0) pend_step = step_no;
        m_pend = (m_pend & ~clr) | set;
        check_eq("keys", 32'(keys), 32'(m_keys));
        check_eq("pending", 32'(pending), 32'(m_pend));
        check_eq("ovr", 32'(ovr), 32'(m_ovr));
        if (irq_req) any_req = 1'b1;
        if (irq_req && !req_prev) begin
            k = lowest(snap);
            check_eq("vec_at_req", 32'(irq_vec), 32'(vec_of(k)));
            cur_k     = k;
            rises++;
            rise_step = step_no;
            gap_last  = step_no - ack_step;
            vecs.push_back(irq_vec);
            ack_wait  = auto_ack ? int'($urandom_range(0, 2)) : 0;
        end else if (irq_req) begin
            check_eq("vec_stable", 32'(irq_vec), 32'(vec_of(cur_k)));
        end
        if (!irq_req && m_pend != '0 && !di) idle_cnt++;
        else idle_cnt = 0;
        if (idle_cnt == 7) check_eq("irq_stall_cycles", 32'(idle_cnt), 32'(6));

        snap     = m_pend;
        req_prev = irq_req;
        ack_was  = 1'b0;
        irq_ack  = 1'b0;
        if (irq_req && (auto_ack || ack_now)) begin
            if (ack_wait <= 0) begin
                irq_ack  = 1'b1;
                ack_was  = 1'b1;
                ack_now  = 1'b0;
                ack_step = step_no;
            end else begin
                ack_wait--;
            end
        end
        di       = di_want;
        phase    = (phase + 1) % 8;
        tick     = (phase == 0);
        tick_was = tick;
        if (phase == 1) begin
            raw_pins = raw_want;
            {btn, Abtn, Bbtn} = ~raw_want;
        end
    endtask

    task automatic run_ticks(input int n);
        repeat (8 * n) step();
    endtask

    // Holds the pressed pattern on the pins for exactly n tick samples, then releases.
    task automatic press_for(input logic [5:0] mask, input int n);
        raw_want = mask;
        do step(); while (phase != 1);
        repeat (8 * n - 1) step();
        raw_want = '0;
        step();
    endtask

    initial begin
        int got;
        model_reset();
        auto_ack = 1'b0; di_want = 1'b0; any_req = 1'b0; phase = 0; rises = 0;
        step_no = 0; ack_step = 0; rise_step = 0; pend_step = 0; gap_last = 0;
        #1;
        check_eq("rst_irq_req", 32'(irq_req), 32'(0));
        check_eq("rst_irq_vec", 32'(irq_vec), 32'(0));
        check_eq("rst_keys", 32'(keys), 32'(0));
        check_eq("rst_pending", 32'(pending), 32'(0));
        check_eq("rst_ovr", 32'(ovr), 32'(0));
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Three-tick glitch must be rejected.
        any_req = 1'b0;
        press_for(6'b000010, 3);
        run_ticks(6);
        check_eq("p034_no_req", 32'(any_req), 32'(0));
        check_eq("p034_keys", 32'(keys), 32'(0));

        // Ten-tick Abtn press, manual ack.
        raw_want = 6'b000010;
        do step(); while (phase != 1);
        repeat (31) step();
        check_eq("p035_keys_before_4th", 32'(keys), 32'(0));
        step();
        check_eq("p035_keys_after_4th", 32'(keys), 32'(6'b000010));
        repeat (8 * 6 - 1) step();
        raw_want = '0;
        step();
        check_eq("p035_pending", 32'(pending), 32'(6'b000010));
        check_eq("p035_irq_req", 32'(irq_req), 32'(1));
        check_eq("p035_irq_vec", 32'(irq_vec), 32'(4));
        check_eq("p035_latency", 32'(rise_step - pend_step), 32'(1));
        ack_now = 1'b1;
        repeat (6) step();
        check_eq("p035_pending_acked", 32'(pending), 32'(0));
        check_eq("p035_req_acked", 32'(irq_req), 32'(0));

        // btn[3] held 60 ticks with auto-repeat.
        auto_ack = 1'b1; rises = 0; vecs.delete();
        press_for(6'b100000, 60);
        run_ticks(8);
        check_eq("p036_events", 32'(rises), 32'(5));
        foreach (vecs[i]) check_eq("p036_vec", 32'(vecs[i]), 32'(12));

        // Bbtn and btn[0] on the same tick.
        rises = 0; vecs.delete();
        press_for(6'b000101, 6);
        run_ticks(2);
        check_eq("p037_events", 32'(rises), 32'(2));
        check_eq("p037_first_vec", 32'(vecs.size() > 0 ? vecs[0] : 8'h0), 32'(2));
        check_eq("p037_second_vec", 32'(vecs.size() > 1 ? vecs[1] : 8'h0), 32'(6));
        check_eq("p037_guard_gap", 32'(gap_last), 32'(4));
        check_eq("p037_ovr", 32'(ovr), 32'(0));

        // Interrupts disabled: requests held back, a second press overruns.
        di_want = 1'b1; any_req = 1'b0;
        press_for(6'b000010, 6);
        run_ticks(6);
        check_eq("p038_pending", 32'(pending), 32'(6'b000010));
        press_for(6'b000010, 6);
        run_ticks(2);
        check_eq("p038_no_req", 32'(any_req), 32'(0));
        check_eq("p038_ovr", 32'(ovr), 32'(1));
        di_want = 1'b0;
        got = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (irq_req) got = 1;
        end
        check_eq("p038_req_after_di", 32'(got), 32'(1));
        run_ticks(2);

        // Random traffic with occasional interrupt-disable windows.
        for (int r = 0; r < 30; r++) begin
            di_want = ($urandom_range(0, 5) == 0);
            press_for(6'($urandom), int'($urandom_range(1, 45)));
            di_want = 1'b0;
            run_ticks(int'($urandom_range(0, 6)));
        end
        run_ticks(8);

        // Asynchronous reset while a request is outstanding.
        auto_ack = 1'b0;
        press_for(6'b000100, 6);
        repeat (8) step();
        check_eq("p039_req_before", 32'(irq_req), 32'(1));
        #2 rst = 1'b0;
        #1;
        check_eq("p039_irq_req", 32'(irq_req), 32'(0));
        check_eq("p039_pending", 32'(pending), 32'(0));
        check_eq("p039_keys", 32'(keys), 32'(0));
        check_eq("p039_ovr", 32'(ovr), 32'(0));
        check_eq("p039_irq_vec", 32'(irq_vec), 32'(0));
        model_reset();
        tick = 1'b0; irq_ack = 1'b0;
        {btn, Abtn, Bbtn} = '1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_ticks(4);
        check_eq("p039_idle_after", 32'(irq_req), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
